// File: rtl/pft_bank_buffer.sv
// Banked PFT buffer: BANKS simple-dual-port banks, shared write port, per-bank read
// address, pipelined matrix/centroid read. Optional macro PFT_WR_FWD_EN adds write-to-read forwarding.
module pft_bank_buffer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LANES  = 16,
    parameter int BANKS  = 32,
    parameter int RD_LAT = 1,
    parameter logic [DATA_W-1:0] FILL = {1'b1, {(DATA_W-1){1'b0}}},
    localparam int IDX_W = $clog2(BANKS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [BANKS-1:0]               wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [LANES*DATA_W-1:0]        wr_data,
    input  logic                           rd_req,
    input  logic [BANKS*ADDR_W-1:0]        rd_addr,
    input  logic [BANKS-1:0]               rd_mask,
    input  logic                           rd_centroid,
    output logic                           rd_vld,
    output logic [BANKS*LANES*DATA_W-1:0]  dout,
    output logic [IDX_W-1:0]               centroid_idx,
    output logic                           none_valid
);

    localparam int WORD_W = LANES * DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LAST   = RD_LAT - 1;

    logic [WORD_W-1:0]       mem_r  [BANKS][DEPTH];
    logic [WORD_W-1:0]       data_r [RD_LAT][BANKS];
    logic [BANKS-1:0]        mask_r [RD_LAT];
    logic [RD_LAT-1:0]       cent_r;
    logic [RD_LAT-1:0]       vld_r;
    logic [BANKS-1:0]        wr_ok_s;
    logic [WORD_W-1:0]       rd_word_s [BANKS];
    logic [IDX_W-1:0]        sel_s;
    logic [BANKS*WORD_W-1:0] nxt_dout_s;
    logic [IDX_W-1:0]        nxt_idx_s;
    logic                    nxt_none_s;

    // Writes presented while reset is held must not land in the banks.
    assign wr_ok_s = wr_en & {BANKS{rst_n}};

    // Bank storage, no reset on contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (wr_ok_s[b]) begin
                mem_r[b][wr_addr] <= wr_data;
            end
        end
    end

    // Per-bank read word, with same-cycle write forwarding when compiled in.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            rd_word_s[b] = mem_r[b][rd_addr[b*ADDR_W +: ADDR_W]];
`ifdef PFT_WR_FWD_EN
            rd_word_s[b] = (wr_ok_s[b] && (wr_addr == rd_addr[b*ADDR_W +: ADDR_W])) ?
                           wr_data : rd_word_s[b];
`endif
        end
    end

    // Data and mask pipeline; payload only, so no reset needed.
    always_ff @(posedge clk) begin
        if (rd_req) begin
            mask_r[0] <= rd_mask;
            for (int b = 0; b < BANKS; b++) begin
                data_r[0][b] <= rd_word_s[b];
            end
        end
        for (int s = 1; s < RD_LAT; s++) begin
            mask_r[s] <= mask_r[s-1];
            for (int b = 0; b < BANKS; b++) begin
                data_r[s][b] <= data_r[s-1][b];
            end
        end
    end

    // Request valid and mode pipeline; cleared by reset so in-flight reads vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= {RD_LAT{1'b0}};
            cent_r <= {RD_LAT{1'b0}};
        end else begin
            vld_r[0]  <= rd_req;
            cent_r[0] <= rd_centroid;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_r[s]  <= vld_r[s-1];
                cent_r[s] <= cent_r[s-1];
            end
        end
    end

    // Result formatting: masked matrix, or the lowest-indexed valid bank's row.
    always_comb begin
        nxt_dout_s = {(BANKS*WORD_W){1'b0}};
        nxt_idx_s  = {IDX_W{1'b0}};
        nxt_none_s = 1'b0;
        sel_s      = {IDX_W{1'b0}};
        for (int b = BANKS - 1; b >= 0; b--) begin
            sel_s = mask_r[LAST][b] ? IDX_W'(b) : sel_s;
        end
        if (cent_r[LAST]) begin
            if (mask_r[LAST] == {BANKS{1'b0}}) begin
                nxt_dout_s[WORD_W-1:0] = {LANES{FILL}};
                nxt_none_s             = 1'b1;
            end else begin
                nxt_dout_s[WORD_W-1:0] = data_r[LAST][sel_s];
                nxt_idx_s              = sel_s;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < BANKS; b++) begin
                    nxt_dout_s[(l*BANKS+b)*DATA_W +: DATA_W] =
                        mask_r[LAST][b] ? data_r[LAST][b][l*DATA_W +: DATA_W] : FILL;
                end
            end
        end
    end

    // Output register; results hold while no new request completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld       <= 1'b0;
            dout         <= {(BANKS*WORD_W){1'b0}};
            centroid_idx <= {IDX_W{1'b0}};
            none_valid   <= 1'b0;
        end else begin
            rd_vld <= vld_r[LAST];
            if (vld_r[LAST]) begin
                dout         <= nxt_dout_s;
                centroid_idx <= nxt_idx_s;
                none_valid   <= nxt_none_s;
            end
        end
    end

endmodule

// File: tb/tb_pft_bank_buffer.sv
// Randomized bench for pft_bank_buffer: RD_LAT=1 and RD_LAT=2 instances share stimulus and
// are checked against a queue-based reference model of the bank contents and read rules.
module tb_pft_bank_buffer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int LANES  = 16;
    localparam int BANKS  = 32;
    localparam int IDX_W  = 5;
    localparam int WORD_W = LANES * DATA_W;
    localparam int OUT_W  = BANKS * WORD_W;
    localparam logic [DATA_W-1:0] FILL_V = 8'h80;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [BANKS-1:0]        wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WORD_W-1:0]       wr_data;
    logic                    rd_req;
    logic [BANKS*ADDR_W-1:0] rd_addr;
    logic [BANKS-1:0]        rd_mask;
    logic                    rd_centroid;
    logic                    vld_a, vld_b;
    logic [OUT_W-1:0]        dout_a, dout_b;
    logic [IDX_W-1:0]        idx_a, idx_b;
    logic                    none_a, none_b;

    always #5 clk = ~clk;

    pft_bank_buffer #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_mask(rd_mask), .rd_centroid(rd_centroid),
        .rd_vld(vld_a), .dout(dout_a), .centroid_idx(idx_a), .none_valid(none_a)
    );

    pft_bank_buffer #(.RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_mask(rd_mask), .rd_centroid(rd_centroid),
        .rd_vld(vld_b), .dout(dout_b), .centroid_idx(idx_b), .none_valid(none_b)
    );

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [IDX_W-1:0] idx;
        logic             none;
        int               issue;
    } exp_t;

    exp_t             res[$];
    int               head [2];
    int               pulses [2];
    logic [OUT_W-1:0] last_d [2];
    logic [IDX_W-1:0] last_idx [2];
    logic             last_none [2];
    logic [WORD_W-1:0] model_mem [BANKS][1 << ADDR_W];
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic flush_model();
        head[0] = res.size();
        head[1] = res.size();
        for (int k = 0; k < 2; k++) begin
            last_d[k]    = '0;
            last_idx[k]  = '0;
            last_none[k] = 1'b0;
        end
    endtask

    // Port k (latency 2+k) must pulse exactly when its oldest pending result comes due.
    task automatic check_port(input int k, input logic vld, input logic [OUT_W-1:0] d,
                              input logic [IDX_W-1:0] idx, input logic none);
        logic due;
        due = 1'b0;
        if (head[k] < res.size()) begin
            due = (res[head[k]].issue + 2 + k == cyc);
        end
        check_val(k == 0 ? "vld_l1" : "vld_l2", {127'd0, vld}, {127'd0, due});
        if (due) begin
            last_d[k]    = res[head[k]].d;
            last_idx[k]  = res[head[k]].idx;
            last_none[k] = res[head[k]].none;
            head[k]++;
        end
        for (int i = 0; i < BANKS; i++) begin
            check_val(k == 0 ? "dout_l1" : "dout_l2", d[i*WORD_W +: WORD_W], last_d[k][i*WORD_W +: WORD_W]);
        end
        check_val(k == 0 ? "idx_l1" : "idx_l2", {123'd0, idx}, {123'd0, last_idx[k]});
        check_val(k == 0 ? "none_l1" : "none_l2", {127'd0, none}, {127'd0, last_none[k]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (vld_a) pulses[0]++;
        if (vld_b) pulses[1]++;
        check_port(0, vld_a, dout_a, idx_a, none_a);
        check_port(1, vld_b, dout_b, idx_b, none_b);
    endtask

    task automatic drive(input logic [BANKS-1:0] we, input logic [ADDR_W-1:0] wa,
                         input logic [WORD_W-1:0] wd, input logic req,
                         input logic [BANKS*ADDR_W-1:0] ra, input logic [BANKS-1:0] m,
                         input logic cent);
        exp_t              e;
        logic [WORD_W-1:0] w;
        logic [ADDR_W-1:0] a;
        bit                found;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = req; rd_addr = ra; rd_mask = m; rd_centroid = cent;
        if (req && rst_n) begin
            e.d = '0; e.idx = '0; e.none = 1'b0; e.issue = cyc; found = 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                a = ra[b*ADDR_W +: ADDR_W];
                w = model_mem[b][a];
`ifdef PFT_WR_FWD_EN
                if (we[b] && wa == a) w = wd;
`endif
                if (!cent) begin
                    for (int l = 0; l < LANES; l++) begin
                        e.d[(l*BANKS+b)*DATA_W +: DATA_W] = m[b] ? w[l*DATA_W +: DATA_W] : FILL_V;
                    end
                end else if (m[b] && !found) begin
                    found = 1'b1;
                    e.idx = IDX_W'(b);
                    e.d[WORD_W-1:0] = w;
                end
            end
            if (cent && !found) begin
                e.d[WORD_W-1:0] = {LANES{FILL_V}};
                e.none = 1'b1;
            end
            res.push_back(e);
        end
        if (rst_n) begin
            for (int b = 0; b < BANKS; b++) begin
                if (we[b]) model_mem[b][wa] = wd;
            end
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [WORD_W-1:0]       wd;
        logic [BANKS*ADDR_W-1:0] ra;
        logic [BANKS-1:0]        m;
        logic [WORD_W-1:0]       val_a, val_b;
        int                      p0, p1, sel;

        rst_n = 1'b0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; rd_mask = '0; rd_centroid = 1'b0;
        pulses[0] = 0; pulses[1] = 0;
        flush_model();
        idle(3);
        rst_n = 1'b1;

        // Fill every bank/address; address 3 holds the b*16+l pattern.
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            for (int b = 0; b < BANKS; b++) begin
                wd = {$urandom, $urandom, $urandom, $urandom};
                if (a == 3) begin
                    for (int l = 0; l < LANES; l++) wd[l*DATA_W +: DATA_W] = 8'(b * 16 + l);
                end
                drive(BANKS'(1) << b, ADDR_W'(a), wd, 1'b0, '0, '0, 1'b0);
            end
        end

        drive('0, '0, '0, 1'b1, {BANKS{5'd3}}, 32'hFFFF_FFFF, 1'b0);
        idle(4);
        check_val("full_b5l2", {120'd0, dout_a[(2*BANKS+5)*DATA_W +: DATA_W]}, 128'h52);

        drive('0, '0, '0, 1'b1, {BANKS{5'd3}}, 32'h0000_00F0, 1'b0);
        idle(4);
        check_val("mask_b4l0", {120'd0, dout_b[4*DATA_W +: DATA_W]}, 128'h40);
        check_val("mask_b3l0", {120'd0, dout_b[3*DATA_W +: DATA_W]}, 128'h80);

        drive('0, '0, '0, 1'b1, {BANKS{5'd3}}, 32'h0001_0100, 1'b1);
        idle(4);
        check_val("cent_idx", {123'd0, idx_a}, 128'd8);
        check_val("cent_l1", {120'd0, dout_a[15:8]}, 128'h81);
        check_val("cent_none", {127'd0, none_a}, 128'd0);

        drive('0, '0, '0, 1'b1, {BANKS{5'd3}}, 32'h0000_0000, 1'b1);
        idle(4);
        check_val("none_set", {127'd0, none_b}, 128'd1);
        check_val("none_word", dout_b[WORD_W-1:0], {LANES{FILL_V}});

        // Back-to-back requests with rotating addresses.
        p0 = pulses[0]; p1 = pulses[1];
        for (int i = 0; i < 20; i++) begin
            for (int b = 0; b < BANKS; b++) ra[b*ADDR_W +: ADDR_W] = ADDR_W'((b + i) % BANKS);
            drive('0, '0, '0, 1'b1, ra, $urandom, i[0]);
        end
        idle(5);
        check_val("b2b_l1", 128'(pulses[0] - p0), 128'd20);
        check_val("b2b_l2", 128'(pulses[1] - p1), 128'd20);

        // Same-cycle write and read of one address.
        val_a = {16{8'hA5}};
        val_b = {16{8'h3C}};
        drive(32'h0000_0004, 5'd5, val_a, 1'b0, '0, '0, 1'b0);
        drive(32'h0000_0004, 5'd5, val_b, 1'b1, {BANKS{5'd5}}, 32'hFFFF_FFFF, 1'b0);
        idle(4);
`ifdef PFT_WR_FWD_EN
        check_val("rw_same", {120'd0, dout_a[2*DATA_W +: DATA_W]}, 128'h3C);
`else
        check_val("rw_same", {120'd0, dout_a[2*DATA_W +: DATA_W]}, 128'hA5);
`endif
        drive('0, '0, '0, 1'b1, {BANKS{5'd5}}, 32'hFFFF_FFFF, 1'b0);
        idle(4);
        check_val("rw_after", {120'd0, dout_b[2*DATA_W +: DATA_W]}, 128'h3C);

        // Reset one cycle after a request; writes under reset are dropped.
        drive('0, '0, '0, 1'b1, {BANKS{5'd3}}, 32'hFFFF_FFFF, 1'b0);
        rst_n = 1'b0;
        flush_model();
        drive(32'hFFFF_FFFF, 5'd3, {WORD_W{1'b1}}, 1'b0, '0, '0, 1'b0);
        drive(32'hFFFF_FFFF, 5'd3, {WORD_W{1'b1}}, 1'b1, {BANKS{5'd3}}, 32'hFFFF_FFFF, 1'b0);
        rst_n = 1'b1;
        drive('0, '0, '0, 1'b1, {BANKS{5'd3}}, 32'hFFFF_FFFF, 1'b0);
        idle(4);
        check_val("rst_b1l0", {120'd0, dout_a[1*DATA_W +: DATA_W]}, 128'h10);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < BANKS; b++) ra[b*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0)      m = '0;
            else if (sel == 1) m = BANKS'(1) << $urandom_range(0, BANKS - 1);
            else               m = $urandom;
            drive(($urandom_range(0, 3) == 0) ? BANKS'($urandom) : '0, ADDR_W'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 2) != 0),
                  ra, m, 1'($urandom));
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pft_bank_buffer.md
# pft_bank_buffer

Parametrised, pipelined successor to the banked PFT buffer: BANKS independent simple-dual-port banks, each LANES×DATA_W wide, with one shared write port and one read address per bank. A read request captures the per-bank valid mask and the centroid mode, then returns either the full masked bank×lane matrix or the lowest-indexed valid bank's row, after a fixed latency with an aligned valid strobe. It sits between the PFT loader and the PE array, replacing the unregistered, fixed-32-bank buffer.

## Interface
- ADDR_W, 5, address bits per bank (depth 2^ADDR_W)
- DATA_W, 8, element width
- LANES, 16, elements per bank word (PE columns)
- BANKS, 32, bank count, ≥2; IDX_W = $clog2(BANKS)
- RD_LAT, 1, bank read latency in cycles, 1 or 2
- FILL, {1'b1,{DATA_W-1{1'b0}}}, value substituted for masked banks

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  BANKS  per-bank write enable; several bits may be set (broadcast)
- wr_addr  in  ADDR_W  write address, shared by all banks
- wr_data  in  LANES*DATA_W  write word
- rd_req  in  1  read request, accepted every cycle
- rd_addr  in  BANKS*ADDR_W  per-bank read address, bank b at [b*ADDR_W +: ADDR_W]
- rd_mask  in  BANKS  per-bank valid mask, sampled with rd_req
- rd_centroid  in  1  centroid mode, sampled with rd_req
- rd_vld  out  1  dout/centroid_idx/none_valid valid
- dout  out  BANKS*LANES*DATA_W  result
- centroid_idx  out  IDX_W  selected bank in centroid mode
- none_valid  out  1  centroid-mode request had an all-zero mask

## Operation
- Write: on each clock with wr_en[b]=1, bank b stores wr_data at wr_addr. No handshake; always accepted.
- Read: on rd_req=1, each bank reads rd_addr[b]; rd_mask and rd_centroid travel through a RD_LAT-deep shift register alongside the bank data; rd_req travels with them as a valid bit.
- Matrix mode (rd_centroid=0): dout[(l*BANKS+b)*DATA_W +: DATA_W] = mask[b] ? bank_b[l] : FILL. centroid_idx=0, none_valid=0.
- Centroid mode: c = lowest b with mask[b]=1. dout[LANES*DATA_W-1:0] = bank_c word (unmasked); all upper bits 0. centroid_idx=c. If mask is all zero: low word = FILL in every lane, centroid_idx=0, none_valid=1.
- Bank outputs sampled when no request is in flight are don't-care; dout and friends hold their last value while rd_vld=0.
- Same-cycle write and read of the same bank and address: read-first (old data), unless forwarding is compiled in (see Configuration).
- Memory contents are not reset and are unknown until written.

## Timing
- Latency L = RD_LAT+1: request at edge t gives rd_vld=1 and data during the cycle after edge t+L.
- Fully pipelined: back-to-back requests give back-to-back rd_vld, one result per cycle, in order.
- rd_vld is a 1-cycle pulse per request; never asserted without a matching request.
- Write at edge t is visible to a read issued at edge t+1 or later.
- Reset values: rd_vld=0, dout=0, centroid_idx=0, none_valid=0; all pipeline valid bits 0.
- Reset mid-operation: in-flight requests are discarded (no rd_vld after release); writes presented while rst_n=0 are ignored; first request after release obeys L normally.
- Mask/mode changing while requests are in flight affects only new requests.

## Configuration
- PFT_WR_FWD_EN defined: a read issued in the same cycle as a write to the same bank and address returns wr_data (write-to-read forwarding, per bank, compare registered alongside the pipeline).
- Undefined: read-first; such a read returns the previous contents. No other behaviour differs.

## Test plan
- Defaults; write bank b addr 3 with lane l = b*16+l for all b; read all banks addr 3, mask all ones, matrix mode -> rd_vld exactly 2 cycles later, every element matches.
- Same data, mask = 32'h0000_00F0, matrix mode -> banks 4–7 return data, all other elements = 8'h80.
- Centroid mode, mask = 32'h0001_0100 -> centroid_idx=8, low 128 bits = bank 8 word, upper bits 0, none_valid=0; mask=0 -> low word all 8'h80, none_valid=1.
- 20 back-to-back requests with rotating addresses, RD_LAT=1 and RD_LAT=2 -> 20 consecutive rd_vld pulses in order at latency 2 and 3.
- Write addr 5 = A, then same-cycle write addr 5 = B with read addr 5 -> returns A without PFT_WR_FWD_EN, B with it; next read returns B.
- Assert rst_n low one cycle after a request -> no rd_vld, outputs 0; request after release returns correct data at latency L.
